// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: multiplexed A/D bus master for the external RTC, one cs/addr-strobe/data-strobe cycle per request.
// Optional write-verify readback is enabled by defining RTC_WR_VERIFY_EN.
module rtc_bus_ctrl #(
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rd_wr,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       verify_err
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, ADDR_HOLD = 3'd2, DATA = 3'd3,
                         DATA_HOLD = 3'd4, GAP = 3'd5, DONE = 3'd6;
  logic [2:0] state, nxt;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [7:0] a_q, d_q, nxt_a, nxt_d;
  logic wr_q, nxt_wr, acc, last, rb, a_ph, d_ph;
  assign acc  = state == IDLE && start;
  assign last = cnt == '0;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:      nxt = acc ? ADDR : IDLE;
      ADDR:      nxt = last ? ADDR_HOLD : ADDR;
      ADDR_HOLD: nxt = last ? DATA : ADDR_HOLD;
      DATA:      nxt = last ? DATA_HOLD : DATA;
      DATA_HOLD: nxt = last ? GAP : DATA_HOLD;
      GAP:       nxt = !last ? GAP : rb ? ADDR : DONE;
      default:   nxt = IDLE;
    endcase
  end
  assign nxt_cnt = nxt == state ? (last ? cnt : cnt - 1'b1) :
                   (nxt == ADDR || nxt == DATA) ? CW'(T_PULSE - 1) :
                   (nxt == ADDR_HOLD || nxt == DATA_HOLD) ? CW'(T_HOLD - 1) :
                   nxt == GAP ? CW'(T_GAP - 1) : '0;
  assign nxt_a  = acc ? addr : a_q;
  assign nxt_d  = acc ? data_in : d_q;
  // the readback pass of a verified write runs as a read
  assign nxt_wr = acc ? rd_wr : rb ? 1'b0 : wr_q;
  assign a_ph   = nxt == ADDR || nxt == ADDR_HOLD;
  assign d_ph   = nxt == DATA || nxt == DATA_HOLD;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      d_q      <= '0;
      wr_q     <= 1'b0;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
      ad_sel   <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= nxt_cnt;
      a_q    <= nxt_a;
      d_q    <= nxt_d;
      wr_q   <= nxt_wr;
      cs_n   <= !(a_ph || d_ph);
      wr_n   <= !(nxt == ADDR || (nxt == DATA && nxt_wr));
      rd_n   <= !(nxt == DATA && !nxt_wr);
      ad_sel <= !a_ph;
      ad_oe  <= a_ph || (d_ph && nxt_wr);
      ad_out <= a_ph ? nxt_a : (d_ph && nxt_wr) ? nxt_d : 8'h00;
      busy   <= nxt != IDLE;
      done   <= nxt == DONE;
      if (state == DATA && last && !wr_q) data_out <= ad_in;
    end
  end
`ifdef RTC_WR_VERIFY_EN
  logic vfy_q;
  // command/transfer registers at F0 and above are not read back
  assign rb = state == GAP && last && wr_q && a_q < 8'hF0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vfy_q      <= 1'b0;
      verify_err <= 1'b0;
    end else if (acc) begin
      vfy_q      <= 1'b0;
      verify_err <= 1'b0;
    end else if (rb) begin
      vfy_q <= 1'b1;
    end else if (state == DATA && last && vfy_q) begin
      verify_err <= ad_in != d_q;
    end
  end
`else
  assign rb = 1'b0;
  assign verify_err = 1'b0;
`endif
endmodule
